// File: rtl/ofdm_symbol_framer.sv
// Trigger-driven framer: drops an offset, then emits frame_len-sample frames with gap_len samples removed between them.
// Zero-latency pass-through in FRAME (o_tready stalls the input); samples outside frames are consumed at full rate.
module ofdm_symbol_framer #(
  parameter int WIDTH    = 32,
  parameter int NUM_CHAN = 1,
  parameter int SR_BASE  = 16,
  parameter int CNT_W    = 16
) (
  input  logic                      ce_clk,
  input  logic                      ce_rst_n,
  input  logic                      set_stb,
  input  logic [7:0]                set_addr,
  input  logic [31:0]               set_data,
  input  logic [WIDTH*NUM_CHAN-1:0] i_tdata,
  input  logic                      i_tuser,
  input  logic                      i_tvalid,
  output logic                      i_tready,
  output logic [WIDTH*NUM_CHAN-1:0] o_tdata,
  output logic                      o_tlast,
  output logic                      o_sof,
  output logic                      o_tvalid,
  input  logic                      o_tready,
  output logic                      o_busy,
  output logic [CNT_W-1:0]          o_frame_idx
);

  typedef enum logic [1:0] {S_IDLE, S_OFFSET, S_FRAME, S_GAP} state_t;

  localparam logic [7:0] LP_A_FLEN  = 8'(SR_BASE);
  localparam logic [7:0] LP_A_GAP   = 8'(SR_BASE + 1);
  localparam logic [7:0] LP_A_OFF   = 8'(SR_BASE + 2);
  localparam logic [7:0] LP_A_MAX   = 8'(SR_BASE + 3);
  localparam logic [7:0] LP_A_MODE  = 8'(SR_BASE + 4);
  localparam logic [7:0] LP_A_ABORT = 8'(SR_BASE + 5);
  localparam logic [CNT_W-1:0] LP_ONE = CNT_W'(1);

  // Shadow (written by settings bus) and active (latched on trigger) configuration
  logic [CNT_W-1:0] r_sh_flen, r_sh_gap, r_sh_off, r_sh_max;
  logic [1:0]       r_sh_mode;
  logic [CNT_W-1:0] r_flen, r_gap, r_off, r_max;
  logic             r_cont, r_retrig;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0] r_fidx, w_fidx_nxt;
  logic             r_abort_pend, w_pend_nxt;
  logic             w_latch;

  logic             w_abort, w_trig, w_trig_fwd, w_in_frame, w_beat;
  logic             w_last, w_done, w_pend, w_cont;
  logic [CNT_W-1:0] w_sh_flen_fix, w_sh_max_fix;
  logic [CNT_W-1:0] w_flen, w_gap, w_max, w_smp, w_fidx, w_fidx_inc;
  logic             w_unused;

  assign w_unused      = &{1'b0, set_data};
  assign w_abort       = set_stb && (set_addr == LP_A_ABORT);
  assign w_sh_flen_fix = (r_sh_flen == '0) ? LP_ONE : r_sh_flen;
  assign w_sh_max_fix  = (r_sh_max == '0) ? LP_ONE : r_sh_max;

  // A trigger beat acts on the shadow config; with zero offset it is already frame sample 0.
  assign w_trig     = i_tvalid && i_tuser && !w_abort &&
                      ((r_state == S_IDLE) ||
                       (r_retrig && ((r_state == S_OFFSET) || (r_state == S_GAP))));
  assign w_trig_fwd = w_trig && (r_sh_off == '0);
  assign w_in_frame = (r_state == S_FRAME) || w_trig_fwd;

  assign i_tready = ce_rst_n && (w_in_frame ? o_tready : 1'b1);
  assign w_beat   = i_tvalid && i_tready;

  assign w_flen     = w_trig ? w_sh_flen_fix : r_flen;
  assign w_gap      = w_trig ? r_sh_gap      : r_gap;
  assign w_max      = w_trig ? w_sh_max_fix  : r_max;
  assign w_cont     = w_trig ? r_sh_mode[0]  : r_cont;
  assign w_smp      = w_trig ? '0 : r_cnt;
  assign w_fidx     = w_trig ? '0 : r_fidx;
  assign w_fidx_inc = w_fidx + LP_ONE;
  assign w_last     = (w_smp == (w_flen - LP_ONE));
  assign w_pend     = (r_state == S_FRAME) && (r_abort_pend || w_abort);
  assign w_done     = w_pend || (!w_cont && (w_fidx_inc == w_max));

  assign o_tdata     = i_tdata;
  assign o_tvalid    = ce_rst_n && w_in_frame && i_tvalid;
  assign o_sof       = o_tvalid && (w_smp == '0);
  assign o_tlast     = o_tvalid && w_last;
  assign o_busy      = (r_state != S_IDLE);
  assign o_frame_idx = r_fidx;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_fidx_nxt  = r_fidx;
    w_pend_nxt  = r_abort_pend;
    w_latch     = 1'b0;
    if (w_abort && (r_state == S_FRAME)) begin
      w_pend_nxt = 1'b1;
    end
    if (w_abort && (r_state != S_FRAME)) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
      w_pend_nxt  = 1'b0;
    end else if (w_beat) begin
      if (w_trig) begin
        w_latch    = 1'b1;
        w_fidx_nxt = '0;
        w_cnt_nxt  = '0;
        w_pend_nxt = 1'b0;
        if (!w_trig_fwd) begin
          if (r_sh_off == LP_ONE) begin
            w_state_nxt = S_FRAME;
          end else begin
            w_state_nxt = S_OFFSET;
            w_cnt_nxt   = LP_ONE;
          end
        end
      end
      if (w_in_frame) begin
        if (w_last) begin
          w_fidx_nxt = w_fidx_inc;
          w_cnt_nxt  = '0;
          if (w_done) begin
            w_state_nxt = S_IDLE;
            w_pend_nxt  = 1'b0;
          end else if (w_gap == '0) begin
            w_state_nxt = S_FRAME;
          end else begin
            w_state_nxt = S_GAP;
          end
        end else begin
          w_state_nxt = S_FRAME;
          w_cnt_nxt   = w_smp + LP_ONE;
        end
      end else if (!w_trig) begin
        case (r_state)
          S_OFFSET: begin
            if (r_cnt == (r_off - LP_ONE)) begin
              w_state_nxt = S_FRAME;
              w_cnt_nxt   = '0;
            end else begin
              w_cnt_nxt = r_cnt + LP_ONE;
            end
          end
          S_GAP: begin
            if (r_cnt == (r_gap - LP_ONE)) begin
              w_state_nxt = S_FRAME;
              w_cnt_nxt   = '0;
            end else begin
              w_cnt_nxt = r_cnt + LP_ONE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge ce_clk or negedge ce_rst_n) begin
    if (!ce_rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_fidx       <= '0;
      r_abort_pend <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_fidx       <= w_fidx_nxt;
      r_abort_pend <= w_pend_nxt;
    end
  end

  // Trigger latches the pre-write shadow values, so a same-cycle write lands in the next burst.
  always_ff @(posedge ce_clk or negedge ce_rst_n) begin
    if (!ce_rst_n) begin
      r_sh_flen <= CNT_W'(64);
      r_sh_gap  <= CNT_W'(16);
      r_sh_off  <= '0;
      r_sh_max  <= LP_ONE;
      r_sh_mode <= 2'b00;
      r_flen    <= CNT_W'(64);
      r_gap     <= CNT_W'(16);
      r_off     <= '0;
      r_max     <= LP_ONE;
      r_cont    <= 1'b0;
      r_retrig  <= 1'b0;
    end else begin
      if (w_latch) begin
        r_flen   <= w_sh_flen_fix;
        r_gap    <= r_sh_gap;
        r_off    <= r_sh_off;
        r_max    <= w_sh_max_fix;
        r_cont   <= r_sh_mode[0];
        r_retrig <= r_sh_mode[1];
      end
      if (set_stb) begin
        case (set_addr)
          LP_A_FLEN: r_sh_flen <= set_data[CNT_W-1:0];
          LP_A_GAP:  r_sh_gap  <= set_data[CNT_W-1:0];
          LP_A_OFF:  r_sh_off  <= set_data[CNT_W-1:0];
          LP_A_MAX:  r_sh_max  <= set_data[CNT_W-1:0];
          LP_A_MODE: r_sh_mode <= set_data[1:0];
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ofdm_symbol_framer.sv
// Directed bench: ramp stimulus into a 1-lane and a 4-lane framer sharing one handshake.
module tb_ofdm_symbol_framer;

  logic        ce_clk = 1'b0;
  logic        ce_rst_n;
  logic        set_stb;
  logic [7:0]  set_addr;
  logic [31:0] set_data;
  logic [31:0] i_tdata;
  logic [63:0] i_tdata4;
  logic        i_tuser, i_tvalid, o_tready;

  logic        i_tready, o_tlast, o_sof, o_tvalid, o_busy;
  logic [31:0] o_tdata;
  logic [15:0] o_frame_idx;
  logic        i_tready4, o_tlast4, o_sof4, o_tvalid4, o_busy4;
  logic [63:0] o_tdata4;
  logic [15:0] o_frame_idx4;

  ofdm_symbol_framer #(.WIDTH(32), .NUM_CHAN(1)) dut (
    .ce_clk(ce_clk), .ce_rst_n(ce_rst_n), .set_stb(set_stb), .set_addr(set_addr),
    .set_data(set_data), .i_tdata(i_tdata), .i_tuser(i_tuser), .i_tvalid(i_tvalid),
    .i_tready(i_tready), .o_tdata(o_tdata), .o_tlast(o_tlast), .o_sof(o_sof),
    .o_tvalid(o_tvalid), .o_tready(o_tready), .o_busy(o_busy), .o_frame_idx(o_frame_idx));

  ofdm_symbol_framer #(.WIDTH(16), .NUM_CHAN(4)) dut4 (
    .ce_clk(ce_clk), .ce_rst_n(ce_rst_n), .set_stb(set_stb), .set_addr(set_addr),
    .set_data(set_data), .i_tdata(i_tdata4), .i_tuser(i_tuser), .i_tvalid(i_tvalid),
    .i_tready(i_tready4), .o_tdata(o_tdata4), .o_tlast(o_tlast4), .o_sof(o_sof4),
    .o_tvalid(o_tvalid4), .o_tready(o_tready), .o_busy(o_busy4), .o_frame_idx(o_frame_idx4));

  always #5 ce_clk = ~ce_clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] v;
  int          trig_a = -1, trig_b = -1, cap_at = -1;
  bit          rand_rdy = 0, seen_trig = 0, abort_done = 0, busy_prev = 0;
  int          busy_fall_v, rdy_diff, fidx_cap;
  logic [33:0] q1[$];
  logic [33:0] eq[$];
  logic [63:0] q4[$];

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] lanes(logic [31:0] x);
    logic [63:0] r;
    for (int k = 0; k < 4; k++) r[16*k +: 16] = 16'(x + 32'(k * 1000));
    return r;
  endfunction

  task automatic drive();
    i_tdata  = v;
    i_tdata4 = lanes(v);
    i_tuser  = (v == trig_a) || (v == trig_b);
    i_tvalid = 1'b1;
    o_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic step();
    bit beat;
    @(negedge ce_clk);
    beat = i_tvalid && i_tready;
    if (beat && i_tuser) seen_trig = 1;
    if (i_tready !== i_tready4 || o_tvalid !== o_tvalid4 || o_tlast !== o_tlast4 ||
        o_sof !== o_sof4 || o_busy !== o_busy4) rdy_diff++;
    if (o_tvalid && o_tready) q1.push_back({o_tdata, o_tlast, o_sof});
    if (o_tvalid4 && o_tready) q4.push_back(o_tdata4);
    if (busy_prev && !o_busy) busy_fall_v = v;
    busy_prev = o_busy;
    if (v == cap_at) fidx_cap = o_frame_idx;
    @(posedge ce_clk);
    #1;
    set_stb = 1'b0;
    if (beat) v++;
    drive();
  endtask

  task automatic wr(int a, int d);
    set_stb  = 1'b1;
    set_addr = 8'(a);
    set_data = 32'(d);
    step();
  endtask

  task automatic cfg(int flen, int gap, int off, int mx, int mode);
    wr(16, flen); wr(17, gap); wr(18, off); wr(19, mx); wr(20, mode);
  endtask

  task automatic start(int vstart, int ta, int tb);
    q1.delete(); q4.delete(); eq.delete();
    seen_trig = 0; abort_done = 0; busy_fall_v = -1; rdy_diff = 0; fidx_cap = -1;
    trig_a = ta; trig_b = tb; v = 32'(vstart);
    drive();
  endtask

  task automatic push_burst(int first, int flen, int gap, int nfr);
    for (int f = 0; f < nfr; f++)
      for (int s = 0; s < flen; s++)
        eq.push_back({32'(first + f * (flen + gap) + s), s == flen - 1, s == 0});
  endtask

  task automatic run(int abort_at, int extra);
    int n = 0;
    while (!(seen_trig && !o_busy && q1.size() >= eq.size()) && n < 6000) begin
      if (v == 32'(abort_at) && !abort_done) begin
        abort_done = 1;
        wr(21, 1);
      end else begin
        step();
      end
      n++;
    end
    check("timeout", 64'(n >= 6000), 0);
    repeat (extra) step();
  endtask

  task automatic compare(string nm);
    check({nm, "_n"}, q1.size(), eq.size());
    check({nm, "_n4"}, q4.size(), eq.size());
    for (int i = 0; i < q1.size() && i < eq.size(); i++)
      check($sformatf("%s_b%0d", nm, i), q1[i], eq[i]);
    for (int i = 0; i < q4.size() && i < eq.size(); i++)
      check($sformatf("%s_l%0d", nm, i), q4[i], lanes(eq[i][33:2]));
    check({nm, "_lanectl"}, rdy_diff, 0);
  endtask

  initial begin
    ce_rst_n = 1'b0; set_stb = 1'b0; set_addr = '0; set_data = '0;
    v = 0; drive();
    i_tuser = 1'b1;
    #12;
    check("rst_tready", i_tready, 0);
    check("rst_tvalid", o_tvalid, 0);
    check("rst_tlast", o_tlast, 0);
    check("rst_sof", o_sof, 0);
    check("rst_busy", o_busy, 0);
    check("rst_fidx", o_frame_idx, 0);
    @(posedge ce_clk); #1;
    ce_rst_n = 1'b1;
    drive();
    repeat (3) step();

    // reference burst
    cfg(64, 16, 22, 12, 0);
    start(90, 100, -1);
    push_burst(122, 64, 16, 12);
    run(-1, 120);
    compare("ref");
    check("ref_busy_fall", busy_fall_v, 122 + 11 * 80 + 63 + 1);
    check("ref_fidx", o_frame_idx, 12);

    // zero offset / zero gap, trigger forwarded from IDLE
    cfg(4, 0, 0, 3, 0);
    start(0, 5, -1);
    push_burst(5, 4, 0, 3);
    run(-1, 40);
    compare("nogap");
    check("nogap_busy_fall", busy_fall_v, 17);

    // backpressure on the reference config
    cfg(64, 16, 22, 12, 0);
    rand_rdy = 1;
    start(90, 100, -1);
    push_burst(122, 64, 16, 12);
    run(-1, 120);
    compare("bp");
    check("bp_busy_fall", busy_fall_v, 1066);
    rand_rdy = 0;

    // retrigger enabled: trigger at 200 lands in the gap after frame 0
    cfg(64, 16, 22, 3, 2);
    start(90, 100, 200);
    cap_at = 201;
    push_burst(122, 64, 16, 1);
    push_burst(222, 64, 16, 3);
    run(-1, 120);
    compare("retrig1");
    check("retrig1_fidx", fidx_cap, 0);

    // retrigger disabled: same stimulus, second trigger ignored
    cfg(64, 16, 22, 3, 0);
    start(90, 100, 200);
    push_burst(122, 64, 16, 3);
    run(-1, 120);
    compare("retrig0");
    check("retrig0_fidx", fidx_cap, 1);
    cap_at = -1;

    // abort at sample 10 of frame 2: frame 2 still completes
    cfg(64, 16, 22, 12, 0);
    start(90, 100, -1);
    push_burst(122, 64, 16, 3);
    run(122 + 160 + 10, 150);
    compare("abort_frame");
    check("abort_frame_fidx", o_frame_idx, 3);
    check("abort_frame_busy_fall", busy_fall_v, 122 + 160 + 64);

    // abort during offset: no output at all
    start(90, 100, -1);
    run(110, 60);
    compare("abort_off");
    check("abort_off_busy_fall", busy_fall_v, 111);

    // reset mid-frame, then defaults (64/16/0/1) take effect
    start(95, 100, -1);
    for (int n = 0; n < 300 && v != 130; n++) step();
    #1;
    check("mid_vld", o_tvalid, 1);
    ce_rst_n = 1'b0;
    #1;
    check("mid_rst_tvalid", o_tvalid, 0);
    check("mid_rst_tvalid4", o_tvalid4, 0);
    check("mid_rst_tready", i_tready, 0);
    check("mid_rst_busy", o_busy, 0);
    check("mid_rst_fidx", o_frame_idx, 0);
    check("mid_rst_tlast", o_tlast, 0);
    @(negedge ce_clk); @(posedge ce_clk); #1;
    ce_rst_n = 1'b1;
    start(300, 310, -1);
    push_burst(310, 64, 16, 1);
    run(-1, 60);
    compare("dflt");
    check("dflt_busy_fall", busy_fall_v, 374);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ofdm_symbol_framer.md
# ofdm_symbol_framer

Parametrised successor to the single-channel periodic framer inside the Schmidl-Cox block. It sits between the timing-sync detector and the FFT. When a sample carries a trigger flag, it:
- drops a programmable offset,
- then emits a programmable number of frame_len-sample frames, removing gap_len (cyclic-prefix) samples between frames,
- marks each frame with tlast and a start-of-frame flag.

New relative to the old framer: NUM_CHAN lanes sharing one handshake, a continuous mode, a deferred abort, a retrigger policy, and status outputs.

## Interface
- WIDTH, 32, bits per channel sample (sc16 = 32)
- NUM_CHAN, 1, lanes in parallel; all lanes are framed identically
- SR_BASE, 16, settings address of register 0 (registers SR_BASE..SR_BASE+5)
- CNT_W, 16, width of the length, offset and frame counters
- ce_clk  in  1  clock
- ce_rst_n  in  1  asynchronous, active-low reset
- set_stb  in  1  settings write strobe
- set_addr  in  8  settings address
- set_data  in  32  settings data
- i_tdata  in  WIDTH*NUM_CHAN  samples; lane 0 in the LSBs
- i_tuser  in  1  trigger flag, qualified by i_tvalid&i_tready
- i_tvalid  in  1  input valid
- i_tready  out  1  input ready
- o_tdata  out  WIDTH*NUM_CHAN  framed samples
- o_tlast  out  1  last sample of a frame
- o_sof  out  1  first sample of a frame
- o_tvalid  out  1  output valid
- o_tready  in  1  output ready
- o_busy  out  1  state != IDLE
- o_frame_idx  out  CNT_W  index of the current or next frame, 0-based

## Operation

**Registers** (reset value in brackets; writes land in the shadow copy):
- SR_BASE+0 frame_len [64]
- SR_BASE+1 gap_len [16]
- SR_BASE+2 offset [0]
- SR_BASE+3 max_frames [1]
- SR_BASE+4 mode [0]:
  - bit0: continuous; ignore max_frames
  - bit1: retrigger; a trigger in GAP or OFFSET restarts the burst
- SR_BASE+5 abort (write of any value)

**Register semantics:**
- Shadow copies are latched into active copies on the trigger beat. Writes mid-burst do not affect the burst in progress.
- frame_len=0 is treated as 1.
- max_frames=0 is treated as 1.

**Beats:** a beat is an accepted input sample (i_tvalid&i_tready). Samples outside FRAME are consumed and discarded.

**States:**
- IDLE
  - i_tready=1; all beats dropped.
  - A beat with i_tuser=1 latches the config, clears frame_idx and the sample counter, then:
    - offset=0: enter FRAME. The trigger beat is frame sample 0 and is forwarded in that same cycle.
    - otherwise: enter OFFSET. The trigger beat is offset sample 0 and is dropped.
- OFFSET
  - Drop beats until offset samples in total (including the trigger beat) have been dropped, then enter FRAME.
- FRAME
  - Pass-through: o_tvalid=i_tvalid, i_tready=o_tready.
  - o_sof=1 on sample 0; o_tlast=1 on sample frame_len-1.
  - On the tlast beat, frame_idx increments. Next state:
    - frame_idx+1 == max_frames and not continuous: IDLE
    - else gap_len=0: FRAME
    - else: GAP
- GAP
  - Drop gap_len beats, then enter FRAME.

**Triggers and abort:**
- i_tuser is ignored in FRAME.
- In OFFSET/GAP, i_tuser is ignored unless retrigger=1. With retrigger=1 the beat acts as a fresh IDLE trigger (relatch config, restart).
- An abort write in IDLE, OFFSET or GAP takes effect on the next cycle (state forced to IDLE).
- In FRAME, abort is deferred: the current frame completes with tlast, then the framer enters IDLE. A frame on the output is never truncated.

**Arithmetic:** counters are CNT_W bits and compare with ==. They never wrap within one count because lengths are at most 2^CNT_W-1. In continuous mode frame_idx wraps modulo 2^CNT_W.

## Timing
- Zero latency: FRAME is a combinational pass-through of data and handshake. Only counters and state are registered.
- State transitions occur on the rising ce_clk edge of the qualifying beat.
- Stall: o_tready=0 in FRAME stalls the input (i_tready=0). Counters advance only on beats.
- Reset:
  - ce_rst_n low clears immediately (async) to: state IDLE, counters 0, registers to the reset values above.
  - While ce_rst_n is low: i_tready=0, o_tvalid=0, o_tlast=0, o_sof=0, o_busy=0, o_frame_idx=0.
  - Reset mid-frame truncates the output; downstream is reset together with this block.
- A settings write and a trigger in the same cycle: the trigger latches the pre-write shadow value. The write applies to the next burst.
- An abort and a trigger in the same cycle in IDLE: the abort wins, and the framer stays in IDLE.

## Test plan
- **Reference burst.** Config frame_len=64, gap=16, offset=22, max=12, NUM_CHAN=1; ramp input, trigger on ramp value 100.
  - Required: 12 frames of 64; the first frame starts at value 122; each later frame starts 80 after the previous.
  - tlast/sof on every frame boundary; returns to IDLE; o_busy=0 after beat 122+11*80+63.
- **offset=0, gap=0, max=3, frame_len=4.** Trigger on value 5.
  - Required: values 5..16 output contiguously; tlast on 8, 12 and 16.
- **Backpressure.** Random o_tready (50%) with the first scenario's config.
  - Required: identical output sequence; no beat lost or duplicated.
- **Retrigger.**
  - retrigger=1, trigger during GAP at value 200: a new burst starts and frame_idx resets to 0.
  - retrigger=0, same stimulus: the trigger is ignored and the original sequence is unchanged.
- **Abort.**
  - Abort written mid-FRAME at sample 10 of frame 2: frame 2 completes (tlast at sample 63), then IDLE.
  - Abort in OFFSET: immediate IDLE with no output.
- **Reset and lanes.**
  - NUM_CHAN=4, WIDTH=16: all lanes are framed identically.
  - Assert ce_rst_n low mid-frame: outputs go to 0 asynchronously and the registers return to their defaults (frame_len reads back as 64 behaviour).
